// File: rtl/swicth_conf_decoder_24.sv
// Configuration packet decoder for one switch.
// It snoops the shared 64-bit configuration bus and accepts beats addressed to
// this switch or to broadcast (id 12'hFFF). It produces registered write strobes
// for pc_max, pc_loop and the conf memory.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | decode matched command beats (SET_MAX, SET_LOOP, WRITE, BURST)
// BURST | accept DATA beats (any id) until remaining hits 0 or an abort
module swicth_conf_decoder_24 #(
  parameter int SWICTH_NUMBER = 0,
  parameter int PC_WIDTH      = 1,
  parameter int CONF_WIDTH    = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [63:0]           conf_bus_in,
  output logic [PC_WIDTH-1:0]   pc_max,
  output logic                  pc_max_we,
  output logic [PC_WIDTH-1:0]   pc_loop,
  output logic                  pc_loop_we,
  output logic                  net_mem_we,
  output logic [PC_WIDTH-1:0]   net_mem_waddr,
  output logic [CONF_WIDTH-1:0] net_mem_data,
  output logic [2:0]            thread_id,
  output logic                  burst_active,
  output logic                  conf_done
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam logic [11:0] SWITCH_ID    = 12'(SWICTH_NUMBER);
  localparam logic [11:0] BROADCAST_ID = 12'hFFF;

  localparam logic [2:0] OP_SET_MAX  = 3'd1;
  localparam logic [2:0] OP_SET_LOOP = 3'd2;
  localparam logic [2:0] OP_WRITE    = 3'd3;
  localparam logic [2:0] OP_BURST    = 3'd4;
  localparam logic [2:0] OP_DATA     = 3'd5;

  state_t              state;
  logic [PC_WIDTH-1:0] next_addr;
  logic [15:0]         remaining;

  logic                  beat_valid;
  logic [2:0]            beat_op;
  logic [11:0]           beat_id;
  logic [2:0]            beat_thread;
  logic [PC_WIDTH-1:0]   beat_addr;
  logic [15:0]           beat_count;
  logic [CONF_WIDTH-1:0] beat_data;
  logic                  id_match;
  logic                  is_cmd;
  logic                  cmd_take;
  logic                  data_take;
  logic                  unused_bits;

  assign beat_valid  = conf_bus_in[63];
  assign beat_op     = conf_bus_in[62:60];
  assign beat_id     = conf_bus_in[59:48];
  assign beat_thread = conf_bus_in[47:45];
  assign beat_addr   = conf_bus_in[PC_WIDTH+31:32];
  assign beat_count  = conf_bus_in[31:16];
  assign beat_data   = conf_bus_in[CONF_WIDTH-1:0];
  assign unused_bits = ^conf_bus_in[44:PC_WIDTH+32];

  assign id_match = beat_valid && ((beat_id == SWITCH_ID) || (beat_id == BROADCAST_ID));
  assign is_cmd   = (beat_op >= OP_SET_MAX) && (beat_op <= OP_BURST);

  // DATA beats in BURST ignore the id field. Matched commands in BURST abort it
  // and are then decoded as IDLE commands in the same cycle.
  assign data_take = (state == BURST) && beat_valid && (beat_op == OP_DATA);
  assign cmd_take  = id_match && ((state == IDLE) || is_cmd);

  assign burst_active = (state == BURST);

  // Decode FSM with registered strobes and held value outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      next_addr     <= '0;
      remaining     <= '0;
      pc_max        <= '0;
      pc_max_we     <= 1'b0;
      pc_loop       <= '0;
      pc_loop_we    <= 1'b0;
      net_mem_we    <= 1'b0;
      net_mem_waddr <= '0;
      net_mem_data  <= '0;
      thread_id     <= '0;
      conf_done     <= 1'b0;
    end else begin
      pc_max_we  <= 1'b0;
      pc_loop_we <= 1'b0;
      net_mem_we <= 1'b0;
      conf_done  <= 1'b0;

      if (data_take) begin
        net_mem_we    <= 1'b1;
        net_mem_waddr <= next_addr;
        net_mem_data  <= beat_data;
        next_addr     <= next_addr + 1'b1;
        remaining     <= remaining - 16'd1;
        if (remaining == 16'd1) begin
          conf_done <= 1'b1;
          state     <= IDLE;
        end
      end else if (cmd_take) begin
        if (state == BURST) begin
          state     <= IDLE;
          remaining <= '0;
        end
        case (beat_op)
          OP_SET_MAX: begin
            pc_max    <= beat_data[PC_WIDTH-1:0];
            pc_max_we <= 1'b1;
            thread_id <= beat_thread;
          end
          OP_SET_LOOP: begin
            pc_loop    <= beat_data[PC_WIDTH-1:0];
            pc_loop_we <= 1'b1;
            thread_id  <= beat_thread;
          end
          OP_WRITE: begin
            net_mem_we    <= 1'b1;
            net_mem_waddr <= beat_addr;
            net_mem_data  <= beat_data;
            thread_id     <= beat_thread;
            conf_done     <= 1'b1;
          end
          OP_BURST: begin
            thread_id <= beat_thread;
            next_addr <= beat_addr;
            remaining <= beat_count;
            state     <= (beat_count != 16'd0) ? BURST : IDLE;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_swicth_conf_decoder_24.sv
// Directed bench for swicth_conf_decoder_24 (SWICTH_NUMBER=5, PC_WIDTH=1).
module tb_swicth_conf_decoder_24;

  localparam int PW = 1;
  localparam int CW = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic [63:0]   conf_bus_in;
  logic [PW-1:0] pc_max;
  logic          pc_max_we;
  logic [PW-1:0] pc_loop;
  logic          pc_loop_we;
  logic          net_mem_we;
  logic [PW-1:0] net_mem_waddr;
  logic [CW-1:0] net_mem_data;
  logic [2:0]    thread_id;
  logic          burst_active;
  logic          conf_done;

  int checks = 0;
  int passes = 0;

  swicth_conf_decoder_24 #(.SWICTH_NUMBER(5), .PC_WIDTH(PW), .CONF_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .conf_bus_in(conf_bus_in),
    .pc_max(pc_max), .pc_max_we(pc_max_we), .pc_loop(pc_loop), .pc_loop_we(pc_loop_we),
    .net_mem_we(net_mem_we), .net_mem_waddr(net_mem_waddr), .net_mem_data(net_mem_data),
    .thread_id(thread_id), .burst_active(burst_active), .conf_done(conf_done)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mk(input logic v, input logic [2:0] op, input logic [11:0] id,
                                     input logic [2:0] th, input logic a, input logic [15:0] cnt,
                                     input logic [23:0] d);
    logic [63:0] b;
    b = '0;
    b[63] = v;
    b[62:60] = op;
    b[59:48] = id;
    b[47:45] = th;
    b[32] = a;
    b[23:0] = d;
    b[31:16] = b[31:16] | cnt;
    return b;
  endfunction

  task automatic send(input logic [63:0] beat);
    conf_bus_in = beat;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [33:0] all_out;
    rst = 1'b1;
    conf_bus_in = '0;
    repeat (2) @(posedge clk);
    #1;
    all_out = {pc_max, pc_max_we, pc_loop, pc_loop_we, net_mem_we, net_mem_waddr, net_mem_data,
               thread_id, conf_done};
    checks++; if (all_out !== '0) $display("FAIL reset_outputs got %h want 0", all_out); else passes++;
    checks++; if (burst_active !== 1'b0) $display("FAIL reset_burst got %b want 0", burst_active); else passes++;
    rst = 1'b0;
  endtask

  task automatic test_set_max;
    send(mk(1, 3'd1, 12'd5, 3'd3, 0, 16'd0, 24'd1));
    checks++; if (pc_max_we !== 1'b1) $display("FAIL set_max_we got %b want 1", pc_max_we); else passes++;
    checks++; if (pc_max !== 1'b1) $display("FAIL set_max_val got %h want 1", pc_max); else passes++;
    checks++; if (thread_id !== 3'd3) $display("FAIL set_max_thread got %0d want 3", thread_id); else passes++;
    checks++; if ({pc_loop_we, net_mem_we, conf_done} !== 3'b000)
      $display("FAIL set_max_other got %b want 000", {pc_loop_we, net_mem_we, conf_done}); else passes++;
    send('0);
    checks++; if ({pc_max_we, pc_max} !== 2'b01)
      $display("FAIL set_max_hold got %b want 01", {pc_max_we, pc_max}); else passes++;
  endtask

  task automatic test_write;
    send(mk(1, 3'd3, 12'hFFF, 3'd6, 1, 16'd0, 24'hABCDEF));
    checks++; if ({net_mem_we, conf_done, net_mem_waddr} !== 3'b111)
      $display("FAIL write_strobe got %b want 111", {net_mem_we, conf_done, net_mem_waddr}); else passes++;
    checks++; if (net_mem_data !== 24'hABCDEF) $display("FAIL write_data got %h want abcdef", net_mem_data); else passes++;
    checks++; if (thread_id !== 3'd6) $display("FAIL write_thread got %0d want 6", thread_id); else passes++;
    send('0);
    checks++; if ({net_mem_we, conf_done} !== 2'b00)
      $display("FAIL write_pulse got %b want 00", {net_mem_we, conf_done}); else passes++;
    checks++; if (net_mem_data !== 24'hABCDEF) $display("FAIL write_hold got %h want abcdef", net_mem_data); else passes++;
  endtask

  task automatic test_burst;
    send(mk(1, 3'd4, 12'd5, 3'd2, 1, 16'd3, 24'd0));
    checks++; if ({burst_active, net_mem_we, thread_id} !== 5'b10010)
      $display("FAIL burst_hdr got %b want 10010", {burst_active, net_mem_we, thread_id}); else passes++;
    send(mk(1, 3'd5, 12'd0, 3'd0, 0, 16'd0, 24'h000011));
    checks++; if ({net_mem_we, net_mem_waddr, conf_done, burst_active} !== 4'b1101 || net_mem_data !== 24'h11)
      $display("FAIL burst_d1 got %b/%h want 1101/11", {net_mem_we, net_mem_waddr, conf_done, burst_active}, net_mem_data); else passes++;
    send(mk(1, 3'd5, 12'd9, 3'd0, 0, 16'd0, 24'h000022));
    checks++; if ({net_mem_we, net_mem_waddr, conf_done, burst_active} !== 4'b1001 || net_mem_data !== 24'h22)
      $display("FAIL burst_d2_wrap got %b/%h want 1001/22", {net_mem_we, net_mem_waddr, conf_done, burst_active}, net_mem_data); else passes++;
    send(mk(0, 3'd5, 12'd5, 3'd0, 0, 16'd0, 24'h0000EE));
    checks++; if ({net_mem_we, burst_active} !== 2'b01)
      $display("FAIL burst_invalid got %b want 01", {net_mem_we, burst_active}); else passes++;
    send(mk(1, 3'd5, 12'd5, 3'd0, 0, 16'd0, 24'h000033));
    checks++; if ({net_mem_we, net_mem_waddr, conf_done, burst_active} !== 4'b1110 || net_mem_data !== 24'h33)
      $display("FAIL burst_d3_done got %b/%h want 1110/33", {net_mem_we, net_mem_waddr, conf_done, burst_active}, net_mem_data); else passes++;
    send(mk(1, 3'd5, 12'd5, 3'd0, 0, 16'd0, 24'h000044));
    checks++; if ({net_mem_we, conf_done, burst_active} !== 3'b000)
      $display("FAIL burst_after got %b want 000", {net_mem_we, conf_done, burst_active}); else passes++;
  endtask

  task automatic test_abort;
    send(mk(1, 3'd4, 12'd5, 3'd1, 0, 16'd4, 24'd0));
    send(mk(1, 3'd5, 12'd5, 3'd0, 0, 16'd0, 24'h000044));
    checks++; if ({net_mem_we, net_mem_waddr, burst_active} !== 3'b101)
      $display("FAIL abort_d1 got %b want 101", {net_mem_we, net_mem_waddr, burst_active}); else passes++;
    send(mk(1, 3'd2, 12'd5, 3'd4, 0, 16'd0, 24'd1));
    checks++; if ({pc_loop_we, pc_loop, burst_active, conf_done, net_mem_we} !== 5'b11000)
      $display("FAIL abort_cmd got %b want 11000", {pc_loop_we, pc_loop, burst_active, conf_done, net_mem_we}); else passes++;
    checks++; if (thread_id !== 3'd4) $display("FAIL abort_thread got %0d want 4", thread_id); else passes++;
    send(mk(1, 3'd5, 12'd5, 3'd0, 0, 16'd0, 24'h000055));
    checks++; if ({net_mem_we, conf_done, burst_active} !== 3'b000)
      $display("FAIL abort_data_ignored got %b want 000", {net_mem_we, conf_done, burst_active}); else passes++;
  endtask

  task automatic test_ignore;
    send(mk(1, 3'd1, 12'd7, 3'd5, 0, 16'd0, 24'd0));
    checks++; if ({pc_max_we, pc_loop_we, net_mem_we, conf_done} !== 4'b0000 || pc_max !== 1'b1)
      $display("FAIL ignore_id got %b/%b want 0000/1", {pc_max_we, pc_loop_we, net_mem_we, conf_done}, pc_max); else passes++;
    send(mk(1, 3'd4, 12'd5, 3'd0, 0, 16'd0, 24'd0));
    checks++; if ({burst_active, net_mem_we, conf_done} !== 3'b000)
      $display("FAIL burst_count0 got %b want 000", {burst_active, net_mem_we, conf_done}); else passes++;
    send(mk(1, 3'd4, 12'd5, 3'd0, 1, 16'd1, 24'd0));
    send(mk(1, 3'd1, 12'd7, 3'd0, 0, 16'd0, 24'd0));
    checks++; if ({burst_active, pc_max_we} !== 2'b10)
      $display("FAIL burst_foreign_hold got %b want 10", {burst_active, pc_max_we}); else passes++;
    send(mk(1, 3'd5, 12'd7, 3'd0, 0, 16'd0, 24'h000077));
    checks++; if ({net_mem_we, net_mem_waddr, conf_done, burst_active} !== 4'b1110)
      $display("FAIL burst_single got %b want 1110", {net_mem_we, net_mem_waddr, conf_done, burst_active}); else passes++;
  endtask

  task automatic test_reset_mid_burst;
    logic [33:0] all_out;
    send(mk(1, 3'd4, 12'd5, 3'd7, 0, 16'd5, 24'd0));
    send(mk(1, 3'd5, 12'd5, 3'd0, 0, 16'd0, 24'h000101));
    send(mk(1, 3'd5, 12'd5, 3'd0, 0, 16'd0, 24'h000202));
    rst = 1'b1;
    send(mk(1, 3'd5, 12'd5, 3'd0, 0, 16'd0, 24'h000303));
    rst = 1'b0;
    all_out = {pc_max, pc_max_we, pc_loop, pc_loop_we, net_mem_we, net_mem_waddr, net_mem_data,
               thread_id, conf_done};
    checks++; if (all_out !== '0 || burst_active !== 1'b0)
      $display("FAIL reset_mid_outputs got %h/%b want 0/0", all_out, burst_active); else passes++;
    send(mk(1, 3'd5, 12'd5, 3'd0, 0, 16'd0, 24'h000404));
    checks++; if ({net_mem_we, conf_done, burst_active} !== 3'b000 || net_mem_data !== '0)
      $display("FAIL reset_mid_data got %b/%h want 000/0", {net_mem_we, conf_done, burst_active}, net_mem_data); else passes++;
  endtask

  initial begin
    rst = 1'b1;
    conf_bus_in = '0;
    test_reset;
    test_set_max;
    test_write;
    test_burst;
    test_abort;
    test_ignore;
    test_reset_mid_burst;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
